keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned matrix keypad with per-frame
// classification, debounce, single-key acceptance and auto-repeat.
module keypad_scanner #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int SCAN_DIV     = 64,
   parameter int DEBOUNCE     = 3,
   parameter int REPEAT_EN    = 0,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [ROWS-1:0]              row_n,
   output logic [COLS-1:0]              col_n,
   output logic [$clog2(ROWS*COLS)-1:0] key_code,
   output logic                         key_valid,
   output logic                         key_held,
   output logic                         key_multi,
   output logic                         frame_tick
);

   localparam int NK  = ROWS * COLS;
   localparam int CW  = $clog2(NK);
   localparam int DW  = $clog2(SCAN_DIV);
   localparam int CIW = $clog2(COLS);
   localparam int RW  = $clog2(REPEAT_DELAY + 1);
   localparam int RRW = $clog2(REPEAT_RATE + 1);

   localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CIW-1:0] COL_LAST = CIW'(COLS - 1);
   localparam logic [3:0]     DEB      = 4'(DEBOUNCE);
   localparam logic [RW-1:0]  RPT_D    = RW'(REPEAT_DELAY);
   localparam logic [RRW-1:0] RPT_R1   = RRW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_HELD,
      S_RELEASE
   } state_t;

   state_t          state, state_nxt;
   logic [ROWS-1:0] row_s1, row_s2;
   logic [DW-1:0]   div_cnt;
   logic [CIW-1:0]  col_idx;
   logic [NK-1:0]   snap, snap_now;
   logic            slot_end, frame_end;
   logic [1:0]      hit_cnt;
   logic [CW-1:0]   hit_code;
   logic            is_none, is_single, is_multi;
   logic [3:0]      deb_cnt, deb_nxt;
   logic [CW-1:0]   cand, cand_nxt;
   logic [CW-1:0]   code_nxt;
   logic            valid_nxt, accept;
   logic [RW-1:0]   rpt_cnt, rpt_nxt;
   logic [RRW-1:0]  rate_cnt, rate_nxt;

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (col_idx == COL_LAST);
   assign key_held  = (state == S_HELD) || (state == S_RELEASE);

   // Two-flop synchroniser; idle rows read as released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_s1 <= '1;
         row_s2 <= '1;
      end else begin
         row_s1 <= row_n;
         row_s2 <= row_s1;
      end
   end

   // Slot divider and column stepper.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         col_idx <= '0;
      end else if (slot_end) begin
         div_cnt <= '0;
         col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + CIW'(1);
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // One-hot active-low column drive from the column index.
   always_comb begin
      col_n = '1;
      for (int c = 0; c < COLS; c++)
         col_n[c] = (col_idx != CIW'(c));
   end

   // Snapshot including the column being sampled this clock.
   always_comb begin
      snap_now = snap;
      if (slot_end)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               if (col_idx == CIW'(c))
                  snap_now[r*COLS+c] = ~row_s2[r];
   end

   // Hold the per-key samples taken at each slot end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         snap <= '0;
      else if (slot_end)
         snap <= snap_now;
   end

   // Classify the frame: none, single (lowest code) or multi.
   always_comb begin
      hit_cnt  = 2'd0;
      hit_code = '0;
      for (int k = 0; k < NK; k++)
         if (snap_now[k]) begin
            if (hit_cnt == 2'd0)
               hit_code = CW'(k);
            if (hit_cnt != 2'd2)
               hit_cnt = hit_cnt + 2'd1;
         end
   end

   assign is_none   = (hit_cnt == 2'd0);
   assign is_single = (hit_cnt == 2'd1);
   assign is_multi  = (hit_cnt == 2'd2);

   // Key FSM state and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_SCAN;
         deb_cnt   <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         rpt_cnt   <= '0;
         rate_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         deb_cnt   <= deb_nxt;
         cand      <= cand_nxt;
         key_code  <= code_nxt;
         key_valid <= valid_nxt;
         rpt_cnt   <= rpt_nxt;
         rate_cnt  <= rate_nxt;
      end
   end

   // Frame-end decisions: debounce, accept, repeat and release.
   always_comb begin
      state_nxt = state;
      deb_nxt   = deb_cnt;
      cand_nxt  = cand;
      code_nxt  = key_code;
      valid_nxt = 1'b0;
      rpt_nxt   = rpt_cnt;
      rate_nxt  = rate_cnt;
      accept    = 1'b0;
      if (frame_end) begin
         unique case (state)
            S_SCAN: begin
               if (is_single) begin
                  cand_nxt = hit_code;
                  if (DEB == 4'd1) begin
                     accept = 1'b1;
                  end else begin
                     deb_nxt   = 4'd1;
                     state_nxt = S_DEBOUNCE;
                  end
               end
            end
            S_DEBOUNCE: begin
               if (is_single && hit_code == cand) begin
                  if (deb_cnt + 4'd1 >= DEB)
                     accept = 1'b1;
                  else
                     deb_nxt = deb_cnt + 4'd1;
               end else begin
                  deb_nxt   = '0;
                  state_nxt = S_SCAN;
               end
            end
            S_HELD: begin
               if (is_single && hit_code == key_code) begin
                  if (REPEAT_EN != 0) begin
                     if (rpt_cnt < RPT_D) begin
                        rpt_nxt = rpt_cnt + RW'(1);
                        if (rpt_cnt + RW'(1) == RPT_D) begin
                           valid_nxt = 1'b1;
                           rate_nxt  = '0;
                        end
                     end else if (rate_cnt == RPT_R1) begin
                        valid_nxt = 1'b1;
                        rate_nxt  = '0;
                     end else begin
                        rate_nxt = rate_cnt + RRW'(1);
                     end
                  end
               end else if (is_none) begin
                  if (DEB == 4'd1) begin
                     deb_nxt   = '0;
                     state_nxt = S_SCAN;
                  end else begin
                     deb_nxt   = 4'd1;
                     state_nxt = S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               if (is_none) begin
                  if (deb_cnt + 4'd1 >= DEB) begin
                     deb_nxt   = '0;
                     state_nxt = S_SCAN;
                  end else begin
                     deb_nxt = deb_cnt + 4'd1;
                  end
               end else if (is_single && hit_code == key_code) begin
                  deb_nxt   = '0;
                  state_nxt = S_HELD;
               end else begin
                  deb_nxt = '0;
               end
            end
            default: state_nxt = S_SCAN;
         endcase
         if (accept) begin
            code_nxt  = hit_code;
            valid_nxt = 1'b1;
            state_nxt = S_HELD;
            deb_nxt   = '0;
            rpt_nxt   = '0;
            rate_nxt  = '0;
         end
      end
   end

   // Frame pulse and multi-key flag, refreshed at each frame end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_tick <= 1'b0;
         key_multi  <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (frame_end)
            key_multi <= is_multi;
      end
   end

endmodule
